// File: rtl/sync_memory_if.sv
// Memory request/response bundle for sync_memory: one shared read/write port
// plus the registered read data and its one-cycle valid strobe.
// Handshake: there is no ready/backpressure. A request is taken on every rising
// edge where EN=1. The requester must capture Data_out on the cycle that
// valid_out=1.
interface sync_memory_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              EN;
  logic              W_R;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Data_in;
  logic [DATA_W-1:0] Data_out;
  logic              valid_out;

  modport master (
    output EN, W_R, Address, Data_in,
    input  Data_out, valid_out
  );

  modport slave (
    input  EN, W_R, Address, Data_in,
    output Data_out, valid_out
  );
endinterface

// File: rtl/sync_memory.sv
// Single-port synchronous RAM with a registered read port and a one-cycle valid strobe.
// Optional MEM_WR_ACK_EN: each write also echoes Data_in on Data_out with valid_out=1.
module sync_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input logic          CLK,
  input logic          RST,
  sync_memory_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              rd_en, wr_en;

  assign rd_en = bus.EN & ~bus.W_R;
  assign wr_en = bus.EN &  bus.W_R;

  // The array sits on the async reset so unwritten words never read X.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[bus.Address] <= bus.Data_in;
    end
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (rd_en) begin
      dout_d  = mem_q[bus.Address];
      valid_d = 1'b1;
    end
`ifdef MEM_WR_ACK_EN
    if (wr_en) begin
      dout_d  = bus.Data_in;
      valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Data_out  = dout_q;
  assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_sync_memory.sv
// Directed self-checking bench for sync_memory; the expected write-cycle response
// follows MEM_WR_ACK_EN when the bench is built with that macro.
module tb_sync_memory;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sync_memory_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  sync_memory #(.DATA_W(32), .ADDR_W(4)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_WR_ACK_EN
  localparam logic WR_VALID = 1'b1;
`else
  localparam logic WR_VALID = 1'b0;
`endif

  // Apply one request, let it take effect on the next rising edge, then settle 1ns.
  task automatic drive(input logic en, input logic wr, input logic [3:0] addr,
                       input logic [31:0] data);
    bus.EN      = en;
    bus.W_R     = wr;
    bus.Address = addr;
    bus.Data_in = data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.EN = 1'b0; bus.W_R = 1'b0; bus.Address = '0; bus.Data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.Data_out !== 32'h0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: got data=%h valid=%b need data=00000000 valid=0",
               bus.Data_out, bus.valid_out);
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 4'd0, 32'h0F0F0F0F);
    drive(1'b1, 1'b0, 4'd0, 32'h0);
    checks++;
    if (bus.Data_out !== 32'h0F0F0F0F || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: got data=%h valid=%b need data=0f0f0f0f valid=1",
               bus.Data_out, bus.valid_out);
    end
    // Assert reset mid-cycle with a read still requested; no clock edge involved.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.Data_out !== 32'h0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got data=%h valid=%b need data=00000000 valid=0",
               bus.Data_out, bus.valid_out);
    end
    bus.EN = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 1'b0, a[3:0], 32'h0);
      checks++;
      if (bus.Data_out !== 32'h0 || bus.valid_out !== 1'b1) begin
        errors++;
        $display("FAIL reset_clear addr=%0d: got data=%h valid=%b need data=00000000 valid=1",
                 a, bus.Data_out, bus.valid_out);
      end
    end
  endtask

  task automatic test_write_read;
    logic [31:0] exp_wr_data;
    exp_wr_data = WR_VALID ? 32'hDEADBEEF : 32'h0;
    drive(1'b1, 1'b1, 4'd3, 32'hDEADBEEF);
    checks++;
    if (bus.Data_out !== exp_wr_data || bus.valid_out !== WR_VALID) begin
      errors++;
      $display("FAIL write_cycle: got data=%h valid=%b need data=%h valid=%b",
               bus.Data_out, bus.valid_out, exp_wr_data, WR_VALID);
    end
    drive(1'b1, 1'b0, 4'd3, 32'h0);
    checks++;
    if (bus.Data_out !== 32'hDEADBEEF || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL read_after_write: got data=%h valid=%b need data=deadbeef valid=1",
               bus.Data_out, bus.valid_out);
    end
    drive(1'b0, 1'b0, 4'd0, 32'h0);
    checks++;
    if (bus.Data_out !== 32'hDEADBEEF || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got data=%h valid=%b need data=deadbeef valid=0",
               bus.Data_out, bus.valid_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] word;
    for (int a = 1; a < 16; a++) begin
      word = 32'h11111111 * a;
      drive(1'b1, 1'b1, a[3:0], word);
      checks++;
      if (bus.valid_out !== WR_VALID) begin
        errors++;
        $display("FAIL b2b_write_valid addr=%0d: got valid=%b need %b",
                 a, bus.valid_out, WR_VALID);
      end
    end
    for (int a = 1; a < 16; a++) begin
      word = 32'h11111111 * a;
      drive(1'b1, 1'b0, a[3:0], 32'h0);
      checks++;
      if (bus.Data_out !== word || bus.valid_out !== 1'b1) begin
        errors++;
        $display("FAIL b2b_read addr=%0d: got data=%h valid=%b need data=%h valid=1",
                 a, bus.Data_out, bus.valid_out, word);
      end
    end
    // Boundary addresses 0 and 15, including an immediate read of the just-written word.
    drive(1'b1, 1'b1, 4'd0, 32'h0BADC0DE);
    drive(1'b1, 1'b0, 4'd0, 32'h0);
    checks++;
    if (bus.Data_out !== 32'h0BADC0DE || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL addr0_read: got data=%h valid=%b need data=0badc0de valid=1",
               bus.Data_out, bus.valid_out);
    end
    drive(1'b1, 1'b0, 4'd15, 32'h0);
    checks++;
    if (bus.Data_out !== 32'hFFFFFFFF || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL addr15_read: got data=%h valid=%b need data=ffffffff valid=1",
               bus.Data_out, bus.valid_out);
    end
  endtask

  task automatic test_en_gating;
    drive(1'b0, 1'b1, 4'd5, 32'h12345678);
    checks++;
    if (bus.Data_out !== 32'hFFFFFFFF || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL en_gate_outputs: got data=%h valid=%b need data=ffffffff valid=0",
               bus.Data_out, bus.valid_out);
    end
    drive(1'b1, 1'b0, 4'd5, 32'h0);
    checks++;
    if (bus.Data_out !== 32'h55555555 || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL en_gate_mem: got data=%h valid=%b need data=55555555 valid=1",
               bus.Data_out, bus.valid_out);
    end
  endtask

  task automatic test_reset_mid_read;
    drive(1'b1, 1'b1, 4'd3, 32'hA5A5A5A5);
    bus.EN = 1'b1; bus.W_R = 1'b0; bus.Address = 4'd3; bus.Data_in = '0;
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.Data_out !== 32'h0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: got data=%h valid=%b need data=00000000 valid=0",
               bus.Data_out, bus.valid_out);
    end
    bus.EN = 1'b0;
    rst_n  = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 32'h0);
    checks++;
    if (bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pulse: got valid=%b need 0", bus.valid_out);
    end
    drive(1'b1, 1'b0, 4'd3, 32'h0);
    checks++;
    if (bus.Data_out !== 32'h0 || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_cleared_addr3: got data=%h valid=%b need data=00000000 valid=1",
               bus.Data_out, bus.valid_out);
    end
  endtask

`ifdef MEM_WR_ACK_EN
  task automatic test_wr_ack;
    drive(1'b1, 1'b1, 4'd7, 32'hCAFEF00D);
    checks++;
    if (bus.Data_out !== 32'hCAFEF00D || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL wr_ack: got data=%h valid=%b need data=cafef00d valid=1",
               bus.Data_out, bus.valid_out);
    end
    drive(1'b0, 1'b0, 4'd0, 32'h0);
    checks++;
    if (bus.Data_out !== 32'hCAFEF00D || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack_single: got data=%h valid=%b need data=cafef00d valid=0",
               bus.Data_out, bus.valid_out);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_en_gating();
    test_reset_mid_read();
`ifdef MEM_WR_ACK_EN
    test_wr_ack();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
